pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the fetch/decode/execute datapath.
- Generates PC, IF_ID and ID_EX register enables, bubble and flush controls from decode-stage operand info, execute-stage branch/busy status and writeback-stage register writes.
- Keeps a per-register pending-write scoreboard and stalls decode on RAW hazards.
- Redirects and flushes the front end on taken branches.

---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: fetch/decode/execute sequencing controller.
// Produces PC / IF_ID / ID_EX enables, bubble and flush controls, keeps a
// per-register pending-write scoreboard for RAW stalls, and redirects the
// front end on taken branches.
// Optional build macro: HAZ_WB_BYPASS_EN -- a source cleared by the same-cycle
// writeback is forwarded and does not stall.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int NUM_REGS  = 32,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              ex_busy,
    input  logic              ex_br_taken,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_we,
    output logic              id_ex_bubble,
    output logic              issue,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0]       FCNT_INIT = 3'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t              state_q, state_d;
    logic [2:0]          fcnt_q, fcnt_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    flushc_q, flushc_d;

    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] pend_src;
    logic                hazard;

    assign stall_cnt = stall_q;
    assign flush_cnt = flushc_q;

    // Writeback clear vector and the pending view used for hazard detection
    always_comb begin
        clr_vec = '0;
        if (wb_we && (wb_rd != '0)) begin
            clr_vec[wb_rd] = 1'b1;
        end
`ifdef HAZ_WB_BYPASS_EN
        pend_src = pend_q & ~clr_vec;
`else
        pend_src = pend_q;
`endif
        hazard = id_valid &&
                 ((id_use_rs1 && pend_src[id_rs1] && (id_rs1 != '0)) ||
                  (id_use_rs2 && pend_src[id_rs2] && (id_rs2 != '0)));
    end

    // Pipeline control outputs, priority busy > branch > flush > hazard > run
    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b0;
        id_ex_bubble = 1'b0;
        issue        = 1'b0;
        if (!reset && !ex_busy) begin
            if (ex_br_taken) begin
                pc_we        = 1'b1;
                if_id_we     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (state_q == FLUSH) begin
                pc_we        = 1'b1;
                if_id_we     = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (hazard) begin
                id_ex_bubble = 1'b1;
            end else begin
                pc_we        = 1'b1;
                if_id_we     = 1'b1;
                id_ex_we     = id_valid;
                id_ex_bubble = ~id_valid;
                issue        = id_valid;
            end
        end
    end

    // Next-state: FSM, flush counter, saturating counters, scoreboard
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        stall_d  = stall_q;
        flushc_d = flushc_q;
        set_vec  = '0;
        if (!ex_busy) begin
            if (ex_br_taken) begin
                state_d = (FLUSH_CYC > 1) ? FLUSH : RUN;
                fcnt_d  = FCNT_INIT;
                if (flushc_q != '1) begin
                    flushc_d = flushc_q + CNT_ONE;
                end
            end else if (state_q == FLUSH) begin
                // fcnt_q holds the FLUSH cycles still to run, this one included
                if (fcnt_q <= 3'd1) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end else if (hazard) begin
                if (stall_q != '1) begin
                    stall_d = stall_q + CNT_ONE;
                end
            end else if (id_valid && id_we && (id_rd != '0)) begin
                set_vec[id_rd] = 1'b1;
            end
        end
        // Clear first so a same-cycle set on the same register wins
        pend_d    = (pend_q & ~clr_vec) | set_vec;
        pend_d[0] = 1'b0;
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= RUN;
            fcnt_q   <= '0;
            pend_q   <= '0;
            stall_q  <= '0;
            flushc_q <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            pend_q   <= pend_d;
            stall_q  <= stall_d;
            flushc_q <= flushc_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (FLUSH_CYC=3). A behavioural model
// tracks pending registers and remaining flush bubbles; outputs are compared
// every cycle, plus hand-computed literal checks at key points.
module tb_pipe_hazard_ctrl;

    localparam int FCYC = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_we;
    logic        ex_busy, ex_br_taken, wb_we;
    logic [4:0]  wb_rd;
    logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, issue;
    logic [15:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .NUM_REGS(32), .FLUSH_CYC(FCYC), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_we(id_we), .ex_busy(ex_busy), .ex_br_taken(ex_br_taken),
        .wb_we(wb_we), .wb_rd(wb_rd), .pc_we(pc_we), .if_id_we(if_id_we),
        .if_id_flush(if_id_flush), .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble),
        .issue(issue), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

`ifdef HAZ_WB_BYPASS_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 2;
`endif

    typedef struct packed {
        logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, issue;
    } ctl_t;

    // Model state: pending registers, remaining post-branch bubbles, counters
    bit [31:0] mpend  = '0;
    int        mflush = 0;
    int        mstall = 0;
    int        mflc   = 0;
    bit        minit  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_hazard();
        bit p1, p2;
        p1 = mpend[id_rs1];
        p2 = mpend[id_rs2];
`ifdef HAZ_WB_BYPASS_EN
        if (wb_we && wb_rd == id_rs1) p1 = 1'b0;
        if (wb_we && wb_rd == id_rs2) p2 = 1'b0;
`endif
        return id_valid && ((id_use_rs1 && p1 && id_rs1 != 0) ||
                            (id_use_rs2 && p2 && id_rs2 != 0));
    endfunction

    function automatic ctl_t m_ctl();
        ctl_t c;
        c = '0;
        if (reset || ex_busy) begin
            c = '0;
        end else if (ex_br_taken) begin
            c.pc_we = 1; c.if_id_we = 1; c.if_id_flush = 1; c.id_ex_bubble = 1;
        end else if (mflush > 0) begin
            c.pc_we = 1; c.if_id_we = 1; c.id_ex_bubble = 1;
        end else if (m_hazard()) begin
            c.id_ex_bubble = 1;
        end else begin
            c.pc_we = 1; c.if_id_we = 1;
            c.id_ex_we = id_valid; c.id_ex_bubble = !id_valid; c.issue = id_valid;
        end
        return c;
    endfunction

    // Model update on the same edge the DUT registers state
    always @(posedge clock) begin : model_upd
        ctl_t c;
        bit   haz;
        if (reset) begin
            mpend = '0; mflush = 0; mstall = 0; mflc = 0; minit = 1'b1;
        end else begin
            c   = m_ctl();
            haz = m_hazard();
            if (!ex_busy) begin
                if (ex_br_taken) begin
                    mflush = FCYC - 1;
                    if (mflc < 65535) mflc++;
                end else if (mflush > 0) begin
                    mflush--;
                end else if (haz) begin
                    if (mstall < 65535) mstall++;
                end
            end
            if (wb_we && wb_rd != 0) mpend[wb_rd] = 1'b0;
            if (c.issue && id_we && id_rd != 0) mpend[id_rd] = 1'b1;
        end
    end

    // Every-cycle comparison away from the active edge
    always @(negedge clock) begin : compare
        ctl_t e;
        e = m_ctl();
        chk("pc_we",        32'(pc_we),        32'(e.pc_we));
        chk("if_id_we",     32'(if_id_we),     32'(e.if_id_we));
        chk("if_id_flush",  32'(if_id_flush),  32'(e.if_id_flush));
        chk("id_ex_we",     32'(id_ex_we),     32'(e.id_ex_we));
        chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.id_ex_bubble));
        chk("issue",        32'(issue),        32'(e.issue));
        if (minit) begin
            chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
            chk("flush_cnt", 32'(flush_cnt), 32'(mflc));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2,
                           input logic [4:0] rd, input logic we);
        id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        id_rd = rd; id_we = we;
    endtask

    initial begin
        reset = 1'b1; ex_busy = 1'b0; ex_br_taken = 1'b1; wb_we = 1'b0; wb_rd = '0;
        set_dec(1, 5, 1, 0, 0, 0, 0);
        #3;
        chk("rst_pc_we", 32'(pc_we), 0);
        chk("rst_issue", 32'(issue), 0);
        chk("rst_flush", 32'(if_id_flush), 0);
        cyc(); cyc();
        reset = 1'b0; ex_br_taken = 1'b0;
        set_dec(1, 1, 1, 2, 1, 0, 0);
        #3;
        chk("first_pc_we", 32'(pc_we), 1);
        chk("first_id_ex_we", 32'(id_ex_we), 1);
        chk("first_issue", 32'(issue), 1);
        chk("first_stall_cnt", 32'(stall_cnt), 0);

        // RAW on r5 with writeback two cycles after issue
        cyc(); set_dec(1, 0, 0, 0, 0, 5, 1);
        cyc(); set_dec(1, 5, 1, 0, 0, 0, 0);
        #3;
        chk("raw_bubble", 32'(id_ex_bubble), 1);
        chk("raw_pc_we", 32'(pc_we), 0);
        cyc(); wb_we = 1; wb_rd = 5;
        cyc(); wb_we = 0;
        #3;
        chk("raw_stall_cnt", 32'(stall_cnt), EXP_STALL);
        chk("raw_resume", 32'(issue), 1);

        // Taken branch, FLUSH_CYC=3
        cyc(); set_dec(1, 1, 1, 2, 1, 0, 0); ex_br_taken = 1;
        #3;
        chk("br_flush", 32'(if_id_flush), 1);
        chk("br_issue", 32'(issue), 0);
        cyc(); ex_br_taken = 0;
        #3;
        chk("fl1_bubble", 32'(id_ex_bubble), 1);
        chk("fl1_flush", 32'(if_id_flush), 0);
        chk("fl1_pc_we", 32'(pc_we), 1);
        cyc();
        #3;
        chk("fl2_bubble", 32'(id_ex_bubble), 1);
        chk("fl2_issue", 32'(issue), 0);
        cyc();
        #3;
        chk("fl_done_issue", 32'(issue), 1);
        chk("flush_cnt_1", 32'(flush_cnt), 1);

        // Busy masks a concurrent branch
        for (int i = 0; i < 4; i++) begin
            cyc(); ex_busy = 1; ex_br_taken = 1;
            #3;
            chk("busy_pc_we", 32'(pc_we), 0);
            chk("busy_if_id_we", 32'(if_id_we), 0);
            chk("busy_id_ex_we", 32'(id_ex_we), 0);
            chk("busy_bubble", 32'(id_ex_bubble), 0);
        end
        cyc(); ex_busy = 0; ex_br_taken = 0;
        #3;
        chk("busy_after_issue", 32'(issue), 1);
        chk("busy_flush_cnt", 32'(flush_cnt), 1);

        // r0 never pending
        cyc(); set_dec(1, 0, 0, 0, 0, 0, 1);
        cyc(); set_dec(1, 0, 1, 0, 1, 0, 0);
        #3;
        chk("r0_issue", 32'(issue), 1);

        // Same-cycle set/clear of r7: set wins
        cyc(); set_dec(1, 0, 0, 0, 0, 7, 1); wb_we = 1; wb_rd = 7;
        cyc(); wb_we = 0; set_dec(1, 0, 0, 7, 1, 0, 0);
        #3;
        chk("r7_bubble", 32'(id_ex_bubble), 1);
        chk("r7_issue", 32'(issue), 0);
        cyc(); wb_we = 1; wb_rd = 7;
        cyc(); wb_we = 0;
        #3;
        chk("r7_resume", 32'(issue), 1);

        // Clear honoured while busy
        cyc(); set_dec(1, 0, 0, 0, 0, 10, 1);
        cyc(); ex_busy = 1; wb_we = 1; wb_rd = 10; set_dec(1, 10, 1, 0, 0, 0, 0);
        cyc(); ex_busy = 0; wb_we = 0;
        #3;
        chk("busy_clr_issue", 32'(issue), 1);

        // Reset during flush with r9 pending
        cyc(); set_dec(1, 0, 0, 0, 0, 9, 1);
        cyc(); set_dec(1, 0, 0, 0, 0, 0, 0); ex_br_taken = 1;
        cyc(); ex_br_taken = 0; reset = 1;
        #3;
        chk("midrst_pc_we", 32'(pc_we), 0);
        cyc(); reset = 0; set_dec(1, 9, 1, 0, 0, 0, 0);
        #3;
        chk("postrst_issue", 32'(issue), 1);
        chk("postrst_flush_cnt", 32'(flush_cnt), 0);

        // Long stall: stall counter saturates
        cyc(); set_dec(1, 0, 0, 0, 0, 3, 1);
        cyc(); set_dec(1, 3, 1, 0, 0, 0, 0);
        repeat (70000) cyc();
        #3;
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        chk("sat_pc_we", 32'(pc_we), 0);
        cyc(); wb_we = 1; wb_rd = 3;
        cyc(); wb_we = 0;
        #3;
        chk("sat_resume", 32'(issue), 1);
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
